parity_frame_rx: RTL and testbench

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_pkg.sv | 9 +
 rtl/odd_check.sv | 9 +
 rtl/parity_frame_rx.sv | 89 ++++++++
 tb/tb_parity_frame_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state encodings and parity-sense constants for the parity frame receiver.
package parity_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;
   localparam logic [1:0] ST_STOP = 2'd3;
   localparam bit PARITY_ODD  = 1'b1;
   localparam bit PARITY_EVEN = 1'b0;
endpackage

// File: rtl/odd_check.sv
// odd_check: XOR-reduce of an N-bit word (1 when the word has an odd number of ones).
module odd_check #(
   parameter int N = 6
) (
   input  logic [N-1:0] din,
   output logic         dout
);
   assign dout = ^din;
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (start, N data bits LSB first, parity, stop)
// with parity and framing error reporting.
module parity_frame_rx #(
   parameter int N          = 6,
   parameter bit PARITY_ODD = parity_pkg::PARITY_ODD
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         bit_valid,
   input  logic         bit_in,
   output logic [N-1:0] data_out,
   output logic         data_valid,
   output logic         parity_err,
   output logic         frame_err,
   output logic         busy
);
   import parity_pkg::*;
   localparam int CW = $clog2(N) + 1;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  shift_q, shift_d, data_q, data_d;
   logic          pbit_q, pbit_d, dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d;
   logic          data_par;
   odd_check #(.N(N)) u_odd_check (
      .din  (shift_q),
      .dout (data_par)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pbit_d  = pbit_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      dv_d    = 1'b0;
      if (bit_valid) begin
         case (state_q)
            ST_IDLE: begin
               state_d = bit_in ? ST_IDLE : ST_DATA;
               cnt_d   = '0;
            end
            ST_DATA: begin
               // shifting in at the MSB end leaves the LSB-first word aligned after N bits
               shift_d = N'({bit_in, shift_q} >> 1);
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CW'(N - 1)) ? ST_PAR : ST_DATA;
            end
            ST_PAR: begin
               pbit_d  = bit_in;
               state_d = ST_STOP;
            end
            default: begin
               data_d  = shift_q;
               perr_d  = (data_par ^ pbit_q) != PARITY_ODD;
               ferr_d  = ~bit_in;
               dv_d    = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         pbit_q  <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pbit_q  <= pbit_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end
   assign data_out   = data_q;
   assign data_valid = dv_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed frames checked against a frame-level model every cycle,
// plus literal expectations for the known frames.
module tb_parity_frame_rx;
   localparam int N    = 6;
   localparam bit PODD = 1'b1;
   logic clk = 1'b0, rst_n = 1'b0, bit_valid = 1'b0, bit_in = 1'b1;
   logic [N-1:0] data_out;
   logic data_valid, parity_err, frame_err, busy;
   int tests = 0, fails = 0, pulses = 0;
   bit started = 1'b0, m_busy = 1'b0;
   int m_n = 0;
   bit [N:0] fbits = '0;
   logic [N-1:0] e_data;
   logic e_dv, e_perr, e_ferr;

   always #5 clk = ~clk;

   parity_frame_rx #(.N(N), .PARITY_ODD(PODD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: gather the N data bits and parity after a start bit, judge on the stop bit.
   always @(posedge clk) begin
      started <= 1'b1;
      e_dv    <= 1'b0;
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_n    <= 0;
         e_data <= '0;
         e_perr <= 1'b0;
         e_ferr <= 1'b0;
      end else if (bit_valid) begin
         if (!m_busy) begin
            m_busy <= !bit_in;
            m_n    <= 0;
         end else if (m_n == N + 1) begin
            e_dv   <= 1'b1;
            e_data <= fbits[N-1:0];
            e_perr <= ($countones(fbits) % 2) != int'(PODD);
            e_ferr <= !bit_in;
            m_busy <= 1'b0;
         end else begin
            fbits[m_n] <= bit_in;
            m_n        <= m_n + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("data_valid", data_valid, e_dv);
         chk("busy", busy, m_busy);
         chk("data_out", data_out, e_data);
         chk("parity_err", parity_err, e_perr);
         chk("frame_err", frame_err, e_ferr);
         if (data_valid === 1'b1) pulses++;
      end
   end

   task automatic send_bit(input logic v, input logic b);
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [N-1:0] d, input logic p, input logic s, input int gap);
      logic [N+2:0] seq;
      seq = {s, p, d, 1'b0};
      for (int i = 0; i < N + 3; i++) begin
         send_bit(1'b1, seq[i]);
         if (i < N + 2) begin
            for (int g = 0; g < gap; g++) begin
               send_bit(1'b0, 1'b0);
               chk("busy in gap", busy, 1'b1);
            end
         end
      end
   endtask

   task automatic chk_pulse(input string nm, input logic [N-1:0] d, input logic pe, input logic fe);
      chk({nm, " dv"}, data_valid, 1'b1);
      chk({nm, " data"}, data_out, d);
      chk({nm, " perr"}, parity_err, pe);
      chk({nm, " ferr"}, frame_err, fe);
      bit_valid = 1'b0;
      bit_in    = 1'b1;
   endtask

   task automatic idle_after(input string nm);
      send_bit(1'b0, 1'b1);
      chk({nm, " pulse width"}, data_valid, 1'b0);
      chk({nm, " busy idle"}, busy, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset data_out", data_out, 0);
      chk("reset dv", data_valid, 0);
      chk("reset busy", busy, 0);
      rst_n = 1'b1;
      send_frame(6'h2D, 1'b1, 1'b1, 0);
      chk_pulse("good", 6'h2D, 1'b0, 1'b0);
      idle_after("good");
      send_frame(6'h2D, 1'b0, 1'b1, 0);
      chk_pulse("bad parity", 6'h2D, 1'b1, 1'b0);
      idle_after("bad parity");
      send_frame(6'h2D, 1'b1, 1'b0, 0);
      chk_pulse("bad stop", 6'h2D, 1'b0, 1'b1);
      idle_after("bad stop");
      send_frame(6'h2D, 1'b1, 1'b1, 3);
      chk_pulse("gapped", 6'h2D, 1'b0, 1'b0);
      idle_after("gapped");
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      chk("busy before abort", busy, 1'b1);
      rst_n     = 1'b0;
      bit_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort data_out", data_out, 0);
      chk("abort dv", data_valid, 0);
      chk("abort busy", busy, 0);
      chk("abort perr", parity_err, 0);
      chk("abort ferr", frame_err, 0);
      rst_n = 1'b1;
      send_frame(6'h00, 1'b1, 1'b1, 0);
      chk_pulse("after reset", 6'h00, 1'b0, 1'b0);
      idle_after("after reset");
      repeat (5) send_bit(1'b1, 1'b1);
      chk("idle ones busy", busy, 1'b0);
      send_frame(6'h2D, 1'b1, 1'b1, 0);
      chk_pulse("b2b first", 6'h2D, 1'b0, 1'b0);
      send_frame(6'h3F, 1'b1, 1'b1, 0);
      chk_pulse("b2b second", 6'h3F, 1'b0, 1'b0);
      idle_after("b2b second");
      repeat (2) send_bit(1'b0, 1'b1);
      chk("pulse count", pulses, 7);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
